// File: rtl/timer_bank.sv
// timer_bank: bank of GBA-style reloadable up-counters with prescaler, optional cascade and overflow/IRQ pulses
// Ports:
//   clock_16, reset_n          - clock, asynchronous active-low reset
//   io_addr, io_write, io_be,
//   bus_wdata                  - MMIO write port, one register word per timer at BASE_IDX+n
//   io_reg_rdata, io_rd_hit    - combinational read data / address hit for io_addr
//   ovf, irq                   - registered one-cycle overflow and gated interrupt pulses
// Register word: [15:0] reload (write) / live counter (read), [17:16] prescale,
//   [18] cascade, [22] irq_en, [23] start.
// Optional feature: define TIMER_CASCADE_EN to store bit 18 and chain timer n's tick
//   to timer n-1's overflow; otherwise every timer uses its prescaler only.
module timer_bank #(
    parameter int         NUM_TIMERS = 4,
    parameter int         CNT_W      = 16,
    parameter logic [9:0] BASE_IDX   = 10'h040
) (
    input  logic                  clock_16,
    input  logic                  reset_n,
    input  logic [11:0]           io_addr,
    input  logic                  io_write,
    input  logic [3:0]            io_be,
    input  logic [31:0]           bus_wdata,
    output logic [31:0]           io_reg_rdata,
    output logic                  io_rd_hit,
    output logic [NUM_TIMERS-1:0] ovf,
    output logic [NUM_TIMERS-1:0] irq
);
    logic [CNT_W-1:0]      cnt_q [NUM_TIMERS];
    logic [CNT_W-1:0]      cnt_d [NUM_TIMERS];
    logic [CNT_W-1:0]      rld_q [NUM_TIMERS];
    logic [CNT_W-1:0]      rld_d [NUM_TIMERS];
    logic [9:0]            pre_q [NUM_TIMERS];
    logic [9:0]            pre_d [NUM_TIMERS];
    logic [1:0]            psc_q [NUM_TIMERS];
    logic [1:0]            psc_d [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] ien_q, ien_d, run_q, run_d, ovf_q, ovf_d, irq_q, irq_d;
`ifdef TIMER_CASCADE_EN
    logic [NUM_TIMERS-1:0] casc_q, casc_d;
`endif
    logic [15:0]           be_mask;
    logic                  unused_bits;

    assign be_mask     = {{8{io_be[1]}}, {8{io_be[0]}}};
    assign unused_bits = ^{io_addr[1:0], io_be[3], bus_wdata, be_mask};
    assign ovf         = ovf_q;
    assign irq         = irq_q;

    always_comb begin
        logic       wr, ctl, live, pre_hit, tick;
        logic [9:0] div_m1;
`ifdef TIMER_CASCADE_EN
        logic       prev;
        prev   = 1'b0;
        casc_d = casc_q;
`endif
        wr      = 1'b0;
        ctl     = 1'b0;
        live    = 1'b0;
        pre_hit = 1'b0;
        tick    = 1'b0;
        div_m1  = '0;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        pre_d   = pre_q;
        psc_d   = psc_q;
        ien_d   = ien_q;
        run_d   = run_q;
        ovf_d   = '0;
        irq_d   = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            wr       = io_write && (io_addr[11:2] == BASE_IDX + 10'(i));
            ctl      = wr && io_be[2];
            rld_d[i] = wr ? (rld_q[i] & ~be_mask[CNT_W-1:0]) | (bus_wdata[CNT_W-1:0] & be_mask[CNT_W-1:0])
                          : rld_q[i];
            psc_d[i] = ctl ? bus_wdata[17:16] : psc_q[i];
            ien_d[i] = ctl ? bus_wdata[22] : ien_q[i];
            run_d[i] = ctl ? bus_wdata[23] : run_q[i];
            // Counting needs the timer running both before and after this cycle's write,
            // so a stop write beats a coincident tick and a start edge only loads.
            live     = run_q[i] && run_d[i];
            div_m1   = psc_q[i] == 2'd0 ? 10'd0 : psc_q[i] == 2'd1 ? 10'd63 :
                       psc_q[i] == 2'd2 ? 10'd255 : 10'd1023;
            pre_hit  = pre_q[i] == div_m1;
            pre_d[i] = (live && !pre_hit) ? pre_q[i] + 10'd1 : 10'd0;
`ifdef TIMER_CASCADE_EN
            casc_d[i] = ctl ? bus_wdata[18] : casc_q[i];
            tick      = live && ((i > 0 && casc_q[i]) ? prev : pre_hit);
`else
            tick      = live && pre_hit;
`endif
            ovf_d[i] = tick && (&cnt_q[i]);
            irq_d[i] = ovf_d[i] && ien_q[i];
            // rld_d already holds any reload written this cycle, so both the start edge
            // and a coincident overflow pick up the new value.
            cnt_d[i] = ((!run_q[i] && run_d[i]) || ovf_d[i]) ? rld_d[i] :
                       tick ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
`ifdef TIMER_CASCADE_EN
            prev = ovf_d[i];
`endif
        end
    end

    always_comb begin
        io_reg_rdata = '0;
        io_rd_hit    = 1'b0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (io_addr[11:2] == BASE_IDX + 10'(i)) begin
                io_rd_hit    = 1'b1;
`ifdef TIMER_CASCADE_EN
                io_reg_rdata = 32'(cnt_q[i]) | {8'd0, run_q[i], ien_q[i], 3'd0, casc_q[i], psc_q[i], 16'd0};
`else
                io_reg_rdata = 32'(cnt_q[i]) | {8'd0, run_q[i], ien_q[i], 3'd0, 1'b0, psc_q[i], 16'd0};
`endif
            end
        end
    end

    always_ff @(posedge clock_16 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                cnt_q[i] <= '0;
                rld_q[i] <= '0;
                pre_q[i] <= '0;
                psc_q[i] <= '0;
            end
            ien_q  <= '0;
            run_q  <= '0;
            ovf_q  <= '0;
            irq_q  <= '0;
`ifdef TIMER_CASCADE_EN
            casc_q <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                cnt_q[i] <= cnt_d[i];
                rld_q[i] <= rld_d[i];
                pre_q[i] <= pre_d[i];
                psc_q[i] <= psc_d[i];
            end
            ien_q  <= ien_d;
            run_q  <= run_d;
            ovf_q  <= ovf_d;
            irq_q  <= irq_d;
`ifdef TIMER_CASCADE_EN
            casc_q <= casc_d;
`endif
        end
    end
endmodule
